hhmm_countdown_timer: RTL and testbench
=======================================

// Module: hhmm_countdown_timer
// PURPOSE
// - HH:MM countdown timer: the down-counting counterpart of the 24-hour BCD clock counter.
// - Loads a BCD start time and decrements once per minute, down to 00:00.
// - Asserts done at 00:00; digits drive the same 7-segment decode path as the clock.
// - Fully synchronous single clock domain; minutes come from an internal prescaler on sec_tick.
// PARAMETERS
// - TICKS_PER_MIN  60  sec_tick pulses per minute decrement; legal range 1..255
// PORTS
// - clk           in   1  system clock
// - rst           in   1  reset, asynchronous, active-high
// - sec_tick      in   1  one-cycle 1 Hz enable strobe
// - load          in   1  one-cycle strobe; captures ld_* digits
// - ld_ht         in   4  load value, hours tens (BCD)
// - ld_ho         in   4  load value, hours ones (BCD)
// - ld_mt         in   4  load value, minutes tens (BCD)
// - ld_mo         in   4  load value, minutes ones (BCD)
// - start         in   1  one-cycle strobe; begin or resume counting
// - pause         in   1  one-cycle strobe; freeze counting
// - hours_tens    out  4  current hours tens digit
// - hours_ones    out  4  current hours ones digit
// - minutes_tens  out  4  current minutes tens digit
// - minutes_ones  out  4  current minutes ones digit
// - running       out  1  high in RUN state
// - done          out  1  one-cycle pulse when count reaches 00:00
// - load_err      out  1  one-cycle pulse when a load value is rejected
// BEHAVIOUR
// - Reset: all digits 0, state IDLE, prescaler 0, running/done/load_err 0.
// - States and transitions:
//   - IDLE:   start -> RUN (at 00:00: -> DONE instead, done pulses).
//   - RUN:    pause -> PAUSED; decrement reaching 00:00 -> DONE.
//   - PAUSED: start -> RUN.
//   - DONE:   start ignored; load -> IDLE.
// - Priority per cycle: rst > load > pause > start > minute decrement.
// - Load validity: ht<=2; ho<=9, or ho<=3 when ht==2; mt<=5; mo<=9.
// - Valid load, any state:
//   - Digits take the ld_* values on the next edge.
//   - Prescaler clears; state -> IDLE.
// - Invalid load:
//   - load_err pulses the next cycle.
//   - Digits, state and prescaler unchanged.
// - Prescaler:
//   - Counts sec_tick only in RUN; held in IDLE/PAUSED/DONE.
//   - Clears on load and on IDLE->RUN.
//   - At TICKS_PER_MIN-1 with sec_tick: wraps to 0 and raises a 1-cycle minute strobe.
// - Decrement (digits update the cycle after the strobe):
//   - mo: 0->9 with borrow.
//   - mt: decrements on borrow; 0->5 with borrow.
//   - ho: decrements on borrow; 0->9 with borrow.
//   - ht: decrements on borrow.
//   - Examples: 20:00 -> 19:59; 10:00 -> 09:59.
// - Reaching 00:00:
//   - done asserts in the same cycle the digits show 00:00.
//   - running drops in that cycle; no further decrement, no underflow past 00:00.
// - Simultaneous strobes:
//   - start and pause together: pause wins.
//   - load with sec_tick: load wins and the tick is dropped.
// - rst asserted mid-count returns everything to reset values immediately (async).
// STRUCTURE
// - Package clock_pkg:
//   - BCD limit constants: HT_MAX=2, HO_MAX=9, HO_MAX_2X=3, MT_MAX=5, MO_MAX=9.
//   - typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} cd_state_t.
// - Sub-module bcd_digit_down, instantiated four times and chained by borrow:
//   - Ports: clk, rst, en, load, ld_val[3:0], wrap_val[3:0], digit[3:0], borrow.
//   - borrow is combinational: en && digit==0.
// - Top level: FSM, prescaler, load validation, zero detect.
// TESTING
// - Load 00:02, start, TICKS_PER_MIN=2, 4 sec_ticks -> 00:01 then 00:00; done 1 cycle; running=0.
// - Load 20:00, start, one minute -> 19:59; load 10:00, one minute -> 09:59.
// - Load 24:00 or 12:60 -> load_err pulse; digits and state unchanged.
// - Load 00:05, start, pause mid-minute, 10 sec_ticks -> digits frozen.
//   - Then start -> prescaler resumes from its held value.
// - load and sec_tick in the same cycle while RUN at 00:01 -> new value, state IDLE, no done.
// - rst pulse mid-RUN at 12:34 -> all outputs 0 and state IDLE before the next clk edge.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: BCD digit limits, countdown FSM states and load-value validation
package clock_pkg;

    localparam logic [3:0] HT_MAX    = 4'd2;
    localparam logic [3:0] HO_MAX    = 4'd9;
    localparam logic [3:0] HO_MAX_2X = 4'd3;
    localparam logic [3:0] MT_MAX    = 4'd5;
    localparam logic [3:0] MO_MAX    = 4'd9;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} cd_state_t;

    // A load is legal only as a real 24-hour time: 00:00..23:59
    function automatic logic bcd_load_ok(input logic [3:0] ht, ho, mt, mo);
        return (ht <= HT_MAX) && (ht == HT_MAX ? ho <= HO_MAX_2X : ho <= HO_MAX) &&
               (mt <= MT_MAX) && (mo <= MO_MAX);
    endfunction

endpackage

// File: rtl/hhmm_countdown_timer_if.sv
// hhmm_countdown_timer_if: control strobes, load digits and displayed digits of the countdown timer
interface hhmm_countdown_timer_if;

    logic       sec_tick;
    logic       load;
    logic [3:0] ld_ht;
    logic [3:0] ld_ho;
    logic [3:0] ld_mt;
    logic [3:0] ld_mo;
    logic       start;
    logic       pause;
    logic [3:0] hours_tens;
    logic [3:0] hours_ones;
    logic [3:0] minutes_tens;
    logic [3:0] minutes_ones;
    logic       running;
    logic       done;
    logic       load_err;

    modport master (
        output sec_tick, load, ld_ht, ld_ho, ld_mt, ld_mo, start, pause,
        input  hours_tens, hours_ones, minutes_tens, minutes_ones, running, done, load_err
    );

    modport slave (
        input  sec_tick, load, ld_ht, ld_ho, ld_mt, ld_mo, start, pause,
        output hours_tens, hours_ones, minutes_tens, minutes_ones, running, done, load_err
    );

endinterface

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one loadable BCD down-counting digit that wraps to wrap_val and borrows at 0
module bcd_digit_down (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] ld_val,
    input  logic [3:0] wrap_val,
    output logic [3:0] digit,
    output logic       borrow
);

    logic [3:0] digit_q, digit_d;

    // Load overrides counting; counting at 0 wraps and raises borrow to the next digit
    always_comb begin
        digit_d = load ? ld_val : en ? (digit_q == 4'd0 ? wrap_val : digit_q - 4'd1) : digit_q;
        borrow  = en && digit_q == 4'd0;
    end

    // Digit register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) digit_q <= 4'd0;
        else     digit_q <= digit_d;
    end

    assign digit = digit_q;

endmodule

// File: rtl/hhmm_countdown_timer.sv
// hhmm_countdown_timer: HH:MM BCD countdown with minute prescaler, run/pause control and done pulse
module hhmm_countdown_timer #(
    parameter int TICKS_PER_MIN = 60
) (
    input logic clk,
    input logic rst,
    hhmm_countdown_timer_if.slave bus
);

    import clock_pkg::*;

    localparam logic [7:0] LAST = 8'(TICKS_PER_MIN - 1);

    cd_state_t  state_q, state_d;
    logic [7:0] presc_q, presc_d;
    logic       min_stb_q, min_stb_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       load_err_q, load_err_d;
    logic       ld_ok, ld_go, in_run, dec, is_zero, is_one;
    logic [3:0] ht, ho, mt, mo;
    logic       mo_borrow, mt_borrow, ho_borrow, ht_borrow;

    // Next-state: load beats pause beats start beats the minute decrement
    always_comb begin
        ld_ok      = bcd_load_ok(bus.ld_ht, bus.ld_ho, bus.ld_mt, bus.ld_mo);
        ld_go      = bus.load && ld_ok;
        in_run     = state_q == RUN && !bus.load && !bus.pause;
        dec        = in_run && min_stb_q;
        is_zero    = {ht, ho, mt, mo} == 16'h0000;
        is_one     = {ht, ho, mt, mo} == 16'h0001;
        state_d    = state_q;
        presc_d    = presc_q;
        min_stb_d  = 1'b0;
        done_d     = 1'b0;
        load_err_d = bus.load && !ld_ok;
        if (bus.load) begin
            if (ld_ok) begin
                state_d = IDLE;
                presc_d = '0;
            end
        end else if (bus.pause) begin
            if (state_q == RUN) state_d = PAUSED;
        end else if (bus.start) begin
            if (state_q == IDLE) begin
                state_d = is_zero ? DONE : RUN;
                done_d  = is_zero;
                presc_d = '0;
            end else if (state_q == PAUSED) begin
                state_d = RUN;
            end
        end
        if (in_run && bus.sec_tick) begin
            presc_d   = presc_q == LAST ? '0 : presc_q + 8'd1;
            min_stb_d = presc_q == LAST;
        end
        if (dec && (is_one || ht_borrow)) begin
            state_d = DONE;
            done_d  = 1'b1;
        end
        running_d = state_d == RUN;
    end

    // FSM state, prescaler and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            min_stb_q  <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            min_stb_q  <= min_stb_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    bcd_digit_down u_mo (.clk(clk), .rst(rst), .en(dec), .load(ld_go), .ld_val(bus.ld_mo),
                         .wrap_val(MO_MAX), .digit(mo), .borrow(mo_borrow));
    bcd_digit_down u_mt (.clk(clk), .rst(rst), .en(mo_borrow), .load(ld_go), .ld_val(bus.ld_mt),
                         .wrap_val(MT_MAX), .digit(mt), .borrow(mt_borrow));
    bcd_digit_down u_ho (.clk(clk), .rst(rst), .en(mt_borrow), .load(ld_go), .ld_val(bus.ld_ho),
                         .wrap_val(HO_MAX), .digit(ho), .borrow(ho_borrow));
    bcd_digit_down u_ht (.clk(clk), .rst(rst), .en(ho_borrow), .load(ld_go), .ld_val(bus.ld_ht),
                         .wrap_val(4'd0), .digit(ht), .borrow(ht_borrow));

    assign bus.hours_tens   = ht;
    assign bus.hours_ones   = ho;
    assign bus.minutes_tens = mt;
    assign bus.minutes_ones = mo;
    assign bus.running      = running_q;
    assign bus.done         = done_q;
    assign bus.load_err     = load_err_q;

endmodule

// File: tb/tb_hhmm_countdown_timer.sv
// tb_hhmm_countdown_timer: directed scenario tests of the HH:MM countdown timer
module tb_hhmm_countdown_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    hhmm_countdown_timer_if bus ();

    hhmm_countdown_timer #(.TICKS_PER_MIN(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {bus.hours_tens, bus.hours_ones, bus.minutes_tens, bus.minutes_ones};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load = 1'b1;
        {bus.ld_ht, bus.ld_ho, bus.ld_mt, bus.ld_mo} = v;
        step(1);
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic do_pause();
        bus.pause = 1'b1;
        step(1);
        bus.pause = 1'b0;
    endtask

    task automatic do_tick();
        bus.sec_tick = 1'b1;
        step(1);
        bus.sec_tick = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        total++; if (digits() !== 16'h0000) begin bad++; $display("FAIL rst_digits got=%h exp=0000", digits()); end
        total++; if ({bus.running, bus.done, bus.load_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {bus.running, bus.done, bus.load_err}); end
        rst = 1'b0;
        step(1);
        total++; if (digits() !== 16'h0000) begin bad++; $display("FAIL rst_release got=%h exp=0000", digits()); end
    endtask

    task automatic test_countdown();
        do_load(16'h0002);
        total++; if (digits() !== 16'h0002) begin bad++; $display("FAIL cd_load got=%h exp=0002", digits()); end
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL cd_idle_run got=%b exp=0", bus.running); end
        do_start();
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL cd_start got=%b exp=1", bus.running); end
        do_tick();
        do_tick();
        total++; if (digits() !== 16'h0002) begin bad++; $display("FAIL cd_strobe_lag got=%h exp=0002", digits()); end
        step(1);
        total++; if (digits() !== 16'h0001) begin bad++; $display("FAIL cd_0001 got=%h exp=0001", digits()); end
        total++; if ({bus.running, bus.done} !== 2'b10) begin bad++; $display("FAIL cd_0001_flags got=%b exp=10", {bus.running, bus.done}); end
        do_tick();
        do_tick();
        step(1);
        total++; if (digits() !== 16'h0000) begin bad++; $display("FAIL cd_0000 got=%h exp=0000", digits()); end
        total++; if ({bus.running, bus.done} !== 2'b01) begin bad++; $display("FAIL cd_done got=%b exp=01", {bus.running, bus.done}); end
        step(1);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL cd_done_pulse got=%b exp=0", bus.done); end
        do_tick();
        do_tick();
        step(1);
        total++; if (digits() !== 16'h0000) begin bad++; $display("FAIL cd_no_underflow got=%h exp=0000", digits()); end
        do_start();
        total++; if ({bus.running, bus.done} !== 2'b00) begin bad++; $display("FAIL cd_done_start got=%b exp=00", {bus.running, bus.done}); end
    endtask

    task automatic test_hours_borrow();
        do_load(16'h2000);
        do_start();
        do_tick();
        do_tick();
        step(1);
        total++; if (digits() !== 16'h1959) begin bad++; $display("FAIL hb_1959 got=%h exp=1959", digits()); end
        do_load(16'h1000);
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL hb_load_idle got=%b exp=0", bus.running); end
        do_start();
        do_tick();
        do_tick();
        step(1);
        total++; if (digits() !== 16'h0959) begin bad++; $display("FAIL hb_0959 got=%h exp=0959", digits()); end
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL hb_running got=%b exp=1", bus.running); end
    endtask

    task automatic test_bad_load();
        do_load(16'h2400);
        total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL bl_2400_err got=%b exp=1", bus.load_err); end
        total++; if (digits() !== 16'h0959) begin bad++; $display("FAIL bl_2400_digits got=%h exp=0959", digits()); end
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL bl_2400_state got=%b exp=1", bus.running); end
        step(1);
        total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL bl_err_pulse got=%b exp=0", bus.load_err); end
        do_load(16'h1260);
        total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL bl_1260_err got=%b exp=1", bus.load_err); end
        total++; if (digits() !== 16'h0959) begin bad++; $display("FAIL bl_1260_digits got=%h exp=0959", digits()); end
        do_tick();
        do_tick();
        step(1);
        total++; if (digits() !== 16'h0958) begin bad++; $display("FAIL bl_keeps_running got=%h exp=0958", digits()); end
        do_load(16'h2359);
        total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL bl_2359_err got=%b exp=0", bus.load_err); end
        total++; if (digits() !== 16'h2359) begin bad++; $display("FAIL bl_2359_digits got=%h exp=2359", digits()); end
    endtask

    task automatic test_pause_resume();
        do_load(16'h0005);
        do_start();
        do_tick();
        do_pause();
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL pr_paused got=%b exp=0", bus.running); end
        repeat (10) do_tick();
        step(1);
        total++; if (digits() !== 16'h0005) begin bad++; $display("FAIL pr_frozen got=%h exp=0005", digits()); end
        do_start();
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL pr_resume got=%b exp=1", bus.running); end
        do_tick();
        step(1);
        total++; if (digits() !== 16'h0004) begin bad++; $display("FAIL pr_held_presc got=%h exp=0004", digits()); end
        bus.start = 1'b1;
        bus.pause = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.pause = 1'b0;
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL pr_pause_wins got=%b exp=0", bus.running); end
    endtask

    task automatic test_load_with_tick();
        do_load(16'h0001);
        do_start();
        do_tick();
        bus.load = 1'b1;
        bus.sec_tick = 1'b1;
        {bus.ld_ht, bus.ld_ho, bus.ld_mt, bus.ld_mo} = 16'h0003;
        step(1);
        bus.load = 1'b0;
        bus.sec_tick = 1'b0;
        total++; if (digits() !== 16'h0003) begin bad++; $display("FAIL lt_digits got=%h exp=0003", digits()); end
        total++; if ({bus.running, bus.done} !== 2'b00) begin bad++; $display("FAIL lt_flags got=%b exp=00", {bus.running, bus.done}); end
        step(1);
        total++; if ({digits(), bus.done} !== {16'h0003, 1'b0}) begin bad++; $display("FAIL lt_no_done got=%h exp=00030", {digits(), bus.done}); end
        do_start();
        do_tick();
        step(1);
        total++; if (digits() !== 16'h0003) begin bad++; $display("FAIL lt_presc_cleared got=%h exp=0003", digits()); end
        do_tick();
        step(1);
        total++; if (digits() !== 16'h0002) begin bad++; $display("FAIL lt_after got=%h exp=0002", digits()); end
    endtask

    task automatic test_start_at_zero();
        do_load(16'h0000);
        do_start();
        total++; if ({bus.running, bus.done} !== 2'b01) begin bad++; $display("FAIL sz_done got=%b exp=01", {bus.running, bus.done}); end
        step(1);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL sz_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_async_reset();
        do_load(16'h1234);
        do_start();
        do_tick();
        total++; if ({digits(), bus.running} !== {16'h1234, 1'b1}) begin bad++; $display("FAIL ar_pre got=%h exp=12341", {digits(), bus.running}); end
        rst = 1'b1;
        #2;
        total++; if (digits() !== 16'h0000) begin bad++; $display("FAIL ar_digits got=%h exp=0000", digits()); end
        total++; if ({bus.running, bus.done, bus.load_err} !== 3'b000) begin bad++; $display("FAIL ar_flags got=%b exp=000", {bus.running, bus.done, bus.load_err}); end
        #2;
        rst = 1'b0;
        step(1);
        total++; if ({digits(), bus.running} !== 17'h0) begin bad++; $display("FAIL ar_idle got=%h exp=0", {digits(), bus.running}); end
    endtask

    initial begin
        bus.sec_tick = 1'b0;
        bus.load = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        {bus.ld_ht, bus.ld_ho, bus.ld_mt, bus.ld_mo} = 16'h0;
        test_reset();
        test_countdown();
        test_hours_borrow();
        test_bad_load();
        test_pause_resume();
        test_load_with_tick();
        test_start_at_zero();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
